timekeeper_lap_controller: RTL and testbench

Parametrised successor to the watch/stop-watch controller. Single-clock block holding a free-running 24 h time-of-day clock and a stop-watch with a lap buffer of LAP_DEPTH entries. Four display modes are selected by a mode FSM. Output is one registered 4-digit packed BCD word for the FND/seven-segment driver. Button inputs arrive already debounced as single-cycle pulses from the existing button-control stage.

---
 rtl/timekeeper_lap_controller_pkg.sv | 43 ++++
 rtl/timekeeper_lap_controller_if.sv | 36 +++
 rtl/timekeeper_lap_controller_bcd_time_counter.sv | 75 +++++++
 rtl/timekeeper_lap_controller.sv | 191 +++++++++++++++++++
 tb/tb_timekeeper_lap_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timekeeper_lap_controller_pkg.sv
// Shared types for the time-keeper / lap controller: mode encodings, BCD time record,
// the blank display code and the BCD increment and stop-watch format helpers.
package timekeeper_pkg;

  typedef enum logic [1:0] {
    MODE_CLK_HM = 2'd0,
    MODE_CLK_SC = 2'd1,
    MODE_SW     = 2'd2,
    MODE_LAP    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] s;
    logic [7:0] cs;
  } bcd_time_t;

  localparam logic [15:0] BLANK_BCD = 16'hFFFF;

  // Two-digit BCD increment; bit 8 is the carry raised when v wraps from max to 00.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [8:0] r;
    if (v == max) begin
      r = {1'b1, 8'h00};
    end else if (v[3:0] == 4'h9) begin
      r = {1'b0, v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {1'b0, v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  function automatic logic [15:0] sw_format(input bcd_time_t t);
    logic [15:0] r;
    if (t.m == 8'h00) begin
      r = {t.s, t.cs};
    end else begin
      r = {t.m, t.s};
    end
    return r;
  endfunction

endpackage

// File: rtl/timekeeper_lap_controller_if.sv
// Button and display bundle of the time-keeper / lap controller, plus a time-of-day
// preload path used to set the clock.
interface timekeeper_lap_controller_if #(
  parameter int LAP_DEPTH = 4
);
  import timekeeper_pkg::*;

  localparam int CW = $clog2(LAP_DEPTH) + 1;

  logic          btn_run_stop;
  logic          btn_clear;
  logic          btn_mode;
  logic          btn_lap;
  logic          preload;
  logic [7:0]    preload_hour;
  bcd_time_t     preload_time;
  logic [15:0]   o_seg_bcd;
  logic [1:0]    o_mode;
  logic          o_running;
  logic [CW-1:0] o_lap_count;
  logic          o_lap_full;
  logic          o_dp;

  modport master (
    output btn_run_stop, btn_clear, btn_mode, btn_lap,
    output preload, preload_hour, preload_time,
    input  o_seg_bcd, o_mode, o_running, o_lap_count, o_lap_full, o_dp
  );

  modport slave (
    input  btn_run_stop, btn_clear, btn_mode, btn_lap,
    input  preload, preload_hour, preload_time,
    output o_seg_bcd, o_mode, o_running, o_lap_count, o_lap_full, o_dp
  );

endinterface

// File: rtl/timekeeper_lap_controller_bcd_time_counter.sv
// Cascaded BCD cs/s/m counter with optional hour field; clear beats load beats enable.
// Minutes wrap at MIN_MAX and carry into the hour only when HAS_HOUR is set.
module bcd_time_counter
  import timekeeper_pkg::*;
#(
  parameter bit         HAS_HOUR = 1'b0,
  parameter logic [7:0] HOUR_MAX = 8'h23,
  parameter logic [7:0] MIN_MAX  = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       load,
  input  bcd_time_t  load_time,
  input  logic [7:0] load_hour,
  output bcd_time_t  count_time,
  output logic [7:0] count_hour
);

  bcd_time_t  value_r;
  logic [7:0] hour_r;
  bcd_time_t  next_value_s;
  logic [7:0] next_hour_s;
  logic       cs_carry_s, s_carry_s, m_carry_s, hour_carry_unused_s;
  logic [7:0] cs_inc_s, s_inc_s, m_inc_s, hour_inc_s;

  assign {cs_carry_s, cs_inc_s}            = bcd_inc(value_r.cs, 8'h99);
  assign {s_carry_s, s_inc_s}              = bcd_inc(value_r.s, 8'h59);
  assign {m_carry_s, m_inc_s}              = bcd_inc(value_r.m, MIN_MAX);
  assign {hour_carry_unused_s, hour_inc_s} = bcd_inc(hour_r, HOUR_MAX);

  // Ripple the carry from centiseconds up through the hour field.
  always_comb begin
    next_value_s    = value_r;
    next_hour_s     = hour_r;
    next_value_s.cs = cs_inc_s;
    if (cs_carry_s) begin
      next_value_s.s = s_inc_s;
      if (s_carry_s) begin
        next_value_s.m = m_inc_s;
        if (m_carry_s && HAS_HOUR) begin
          next_hour_s = hour_inc_s;
        end else begin
          next_hour_s = hour_r;
        end
      end else begin
        next_value_s.m = value_r.m;
      end
    end else begin
      next_value_s.s = value_r.s;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
      hour_r  <= 8'h00;
    end else if (clear) begin
      value_r <= '0;
      hour_r  <= 8'h00;
    end else if (load) begin
      value_r <= load_time;
      hour_r  <= HAS_HOUR ? load_hour : 8'h00;
    end else if (enable) begin
      value_r <= next_value_s;
      hour_r  <= next_hour_s;
    end
  end

  assign count_time = value_r;
  assign count_hour = hour_r;

endmodule

// File: rtl/timekeeper_lap_controller.sv
// Time-of-day clock plus stop-watch with circular lap buffer and 4-mode BCD display.
// Build option LAP_OVERWRITE_EN: a capture into a full buffer replaces the oldest lap.
module timekeeper_lap_controller
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  timekeeper_lap_controller_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(LAP_DEPTH);
  localparam int CW  = IW + 1;

  logic [PW-1:0] pre_cnt_r;
  logic          tick_s;
  mode_e         mode_r;
  logic          running_r;
  bcd_time_t     lap_mem_r [LAP_DEPTH];
  logic [IW-1:0] lap_base_r;
  logic [CW-1:0] lap_count_r;
  logic          lap_full_r;
  logic [IW-1:0] view_r;
  logic [15:0]   seg_r;
  logic [1:0]    mode_out_r;
  logic          dp_r;

  bcd_time_t     tod_time_s, sw_time_s;
  logic [7:0]    tod_hour_s, sw_hour_unused_s;
  logic          sw_clear_s, lap_capture_s;
  logic [IW-1:0] wr_idx_s, rd_idx_s;
  logic [15:0]   disp_s;
  logic          dp_s;

  assign tick_s = (pre_cnt_r == PW'(DIV - 1));

  // Free-running time-base prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end
  end

  assign sw_clear_s    = !bus.btn_mode && (mode_r == MODE_SW) && bus.btn_clear && !running_r;
  assign lap_capture_s = !bus.btn_mode && (mode_r == MODE_SW) && bus.btn_lap && running_r;
  assign wr_idx_s      = lap_base_r + IW'(lap_count_r);
  assign rd_idx_s      = lap_base_r + view_r;

  bcd_time_counter #(.HAS_HOUR(1'b1), .HOUR_MAX(8'h23), .MIN_MAX(8'h59)) u_tod (
    .clk        (clk),
    .rst_n      (reset),
    .enable     (tick_s),
    .clear      (1'b0),
    .load       (bus.preload),
    .load_time  (bus.preload_time),
    .load_hour  (bus.preload_hour),
    .count_time (tod_time_s),
    .count_hour (tod_hour_s)
  );

  bcd_time_counter #(.HAS_HOUR(1'b0), .HOUR_MAX(8'h00), .MIN_MAX(8'h59)) u_sw (
    .clk        (clk),
    .rst_n      (reset),
    .enable     (tick_s && running_r),
    .clear      (sw_clear_s),
    .load       (1'b0),
    .load_time  ('0),
    .load_hour  (8'h00),
    .count_time (sw_time_s),
    .count_hour (sw_hour_unused_s)
  );

  // Mode FSM with run/stop, lap capture and lap browsing; btn_mode masks the other buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r      <= MODE_CLK_HM;
      running_r   <= 1'b0;
      lap_base_r  <= '0;
      lap_count_r <= '0;
      lap_full_r  <= 1'b0;
      view_r      <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_mem_r[i] <= '0;
      end
    end else if (bus.btn_mode) begin
      case (mode_r)
        MODE_CLK_HM: mode_r <= MODE_CLK_SC;
        MODE_CLK_SC: mode_r <= MODE_SW;
        MODE_SW: begin
          mode_r <= MODE_LAP;
          view_r <= '0;
        end
        MODE_LAP:    mode_r <= MODE_CLK_HM;
        default:     mode_r <= MODE_CLK_HM;
      endcase
    end else begin
      case (mode_r)
        MODE_SW: begin
          if (bus.btn_run_stop) begin
            running_r <= !running_r;
          end
          if (lap_capture_s) begin
            if (!lap_full_r) begin
              lap_mem_r[wr_idx_s] <= sw_time_s;
              lap_count_r         <= lap_count_r + CW'(1);
              lap_full_r          <= (lap_count_r == CW'(LAP_DEPTH - 1));
            end else begin
`ifdef LAP_OVERWRITE_EN
              lap_mem_r[lap_base_r] <= sw_time_s;
              lap_base_r            <= lap_base_r + IW'(1);
`else
              lap_count_r           <= lap_count_r;
`endif
            end
          end
        end
        MODE_LAP: begin
          if (bus.btn_clear) begin
            lap_base_r  <= '0;
            lap_count_r <= '0;
            lap_full_r  <= 1'b0;
            view_r      <= '0;
          end else if (bus.btn_lap && (lap_count_r != '0)) begin
            view_r <= ((CW'(view_r) + CW'(1)) == lap_count_r) ? '0 : view_r + IW'(1);
          end
        end
        default: begin
          running_r <= running_r;
        end
      endcase
    end
  end

  // Display word and colon for the current mode; the half-second blink follows cs.
  always_comb begin
    disp_s = 16'h0000;
    dp_s   = 1'b1;
    case (mode_r)
      MODE_CLK_HM: begin
        disp_s = {tod_hour_s, tod_time_s.m};
        dp_s   = (tod_time_s.cs < 8'h50);
      end
      MODE_CLK_SC: begin
        disp_s = {tod_time_s.s, tod_time_s.cs};
        dp_s   = 1'b1;
      end
      MODE_SW: begin
        disp_s = sw_format(sw_time_s);
        dp_s   = running_r ? (sw_time_s.cs < 8'h50) : 1'b1;
      end
      MODE_LAP: begin
        disp_s = (lap_count_r == '0) ? BLANK_BCD : sw_format(lap_mem_r[rd_idx_s]);
        dp_s   = 1'b1;
      end
      default: begin
        disp_s = 16'h0000;
        dp_s   = 1'b1;
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r      <= 16'h0000;
      mode_out_r <= 2'd0;
      dp_r       <= 1'b1;
    end else begin
      seg_r      <= disp_s;
      mode_out_r <= mode_r;
      dp_r       <= dp_s;
    end
  end

  assign bus.o_seg_bcd   = seg_r;
  assign bus.o_mode      = mode_out_r;
  assign bus.o_dp        = dp_r;
  assign bus.o_running   = running_r;
  assign bus.o_lap_count = lap_count_r;
  assign bus.o_lap_full  = lap_full_r;

endmodule

// File: tb/tb_timekeeper_lap_controller.sv
// Self-checking bench: directed scenarios plus random button traffic, compared each
// cycle against a centisecond-integer reference model of the controller.
module tb_timekeeper_lap_controller;
  import timekeeper_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEPTH = 4;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DAY_CS = 24 * 60 * 60 * 100;
  localparam int HOUR_CS = 60 * 60 * 100;
  localparam int SW_CS = 60 * 60 * 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timekeeper_lap_controller_if #(.LAP_DEPTH(DEPTH)) bus ();

  timekeeper_lap_controller #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_phase, m_tod, m_sw, m_mode, m_view;
  bit m_run;
  int laps[$];
  int caps[5];
  logic [15:0] e_seg;
  logic [1:0] e_mode;
  logic e_dp;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [15:0] sw_fmt(input int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return (mm == 0) ? {bcd2(ss), bcd2(cc)} : {bcd2(mm), bcd2(ss)};
  endfunction

  function automatic logic [15:0] disp_of();
    case (m_mode)
      0: return {bcd2(m_tod / HOUR_CS), bcd2((m_tod / 6000) % 60)};
      1: return {bcd2((m_tod / 100) % 60), bcd2(m_tod % 100)};
      2: return sw_fmt(m_sw);
      default: return (laps.size() == 0) ? 16'hFFFF : sw_fmt(laps[m_view]);
    endcase
  endfunction

  function automatic logic dp_of();
    if (m_mode == 0) return ((m_tod % 100) < 50);
    if (m_mode == 2 && m_run) return ((m_sw % 100) < 50);
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_tod = 0; m_sw = 0; m_mode = 0; m_view = 0; m_run = 1'b0;
    laps.delete();
  endtask

  task automatic model_advance(input bit bm, input bit brs, input bit bc, input bit bl,
                               input bit pl, input int pl_val);
    bit tick, clr, cap;
    int old_sw;
    tick = (m_phase == DIV - 1);
    m_phase = (m_phase + 1) % DIV;
    clr = !bm && m_mode == 2 && bc && !m_run;
    cap = !bm && m_mode == 2 && bl && m_run;
    old_sw = m_sw;
    if (pl) m_tod = pl_val;
    else if (tick) m_tod = (m_tod + 1) % DAY_CS;
    if (clr) m_sw = 0;
    else if (tick && m_run) m_sw = (m_sw + 1) % SW_CS;
    if (bm) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 3) m_view = 0;
    end else if (m_mode == 2) begin
      if (cap) begin
        if (laps.size() < DEPTH) begin
          laps.push_back(old_sw);
        end else begin
`ifdef LAP_OVERWRITE_EN
          void'(laps.pop_front());
          laps.push_back(old_sw);
`endif
        end
      end
      if (brs) m_run = !m_run;
    end else if (m_mode == 3) begin
      if (bc) begin
        laps.delete();
        m_view = 0;
      end else if (bl && laps.size() > 0) begin
        m_view = (m_view + 1) % laps.size();
      end
    end
  endtask

  task automatic check_all();
    check_eq("seg", bus.o_seg_bcd, e_seg);
    check_eq("mode", bus.o_mode, e_mode);
    check_eq("dp", bus.o_dp, e_dp);
    check_eq("running", bus.o_running, m_run);
    check_eq("lap_count", bus.o_lap_count, laps.size());
    check_eq("lap_full", bus.o_lap_full, laps.size() == DEPTH);
  endtask

  task automatic step(input bit bm, input bit brs, input bit bc, input bit bl,
                      input bit pl, input int pl_val);
    bus.btn_mode = bm;
    bus.btn_run_stop = brs;
    bus.btn_clear = bc;
    bus.btn_lap = bl;
    bus.preload = pl;
    bus.preload_hour = bcd2(pl_val / HOUR_CS);
    bus.preload_time = {bcd2((pl_val / 6000) % 60), bcd2((pl_val / 100) % 60), bcd2(pl_val % 100)};
    e_seg = disp_of();
    e_mode = 2'(m_mode);
    e_dp = dp_of();
    model_advance(bm, brs, bc, bl, pl, pl_val);
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_run_stop = 1'b0;
    bus.btn_clear = 1'b0;
    bus.btn_lap = 1'b0;
    bus.preload = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg"}, bus.o_seg_bcd, 16'h0000);
    check_eq({tag, "_mode"}, bus.o_mode, 2'd0);
    check_eq({tag, "_dp"}, bus.o_dp, 1'b1);
    check_eq({tag, "_running"}, bus.o_running, 1'b0);
    check_eq({tag, "_count"}, bus.o_lap_count, 3'd0);
    check_eq({tag, "_full"}, bus.o_lap_full, 1'b0);
  endtask

  initial begin
    int n, r;
    bus.btn_mode = 1'b0; bus.btn_run_stop = 1'b0; bus.btn_clear = 1'b0; bus.btn_lap = 1'b0;
    bus.preload = 1'b0; bus.preload_hour = 8'h00; bus.preload_time = '0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // first tick seen in CLK_SC
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(10);
    check_eq("sc_first_tick", bus.o_seg_bcd, 16'h0001);
    check_eq("sc_dp", bus.o_dp, 1'b1);

    // day wrap from 23:59:59.99
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DAY_CS - 1);
    idle(11);
    check_eq("tod_wrap", bus.o_seg_bcd, 16'h0000);

    // stop-watch to 1:01.00, stop, clear
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n = 0;
    while (m_sw != 6100 && n < 70000) begin idle(1); n++; end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("sw_0101", bus.o_seg_bcd, 16'h0101);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("sw_cleared", bus.o_seg_bcd, 16'h0000);

    // lap on the same cycle as tick keeps the pre-increment value
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    n = 0;
    while (!(m_sw == 1234 && m_phase == DIV - 1) && n < 20000) begin idle(1); n++; end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("lap_on_tick", bus.o_seg_bcd, 16'h1234);

    // clear buffer, then five captures into a four-deep buffer
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("lap_empty", bus.o_seg_bcd, 16'hFFFF);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      caps[i] = m_sw;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      idle(12);
    end
    check_eq("full_count", bus.o_lap_count, 3'd4);
    check_eq("full_flag", bus.o_lap_full, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(1);
`ifdef LAP_OVERWRITE_EN
    check_eq("lap_view0", bus.o_seg_bcd, sw_fmt(caps[1]));
`else
    check_eq("lap_view0", bus.o_seg_bcd, sw_fmt(caps[0]));
`endif
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(1);

    // btn_mode masks btn_run_stop in SW mode
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(1);
    check_eq("prio_mode", bus.o_mode, 2'd3);
    check_eq("prio_running", bus.o_running, 1'b1);

    // random button traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 39));
      case (r)
        0: step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        1: step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        2: step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        3, 4, 5: step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        6: step(1'b1, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b0, 1'b0, 0);
        7: step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        8: step(1'b0, 1'b0, 1'b0, 1'b0, ($urandom_range(0, 7) == 0), int'($urandom_range(0, DAY_CS - 1)));
        default: idle(1);
      endcase
    end

    // asynchronous reset in the middle of a run
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
